// File: rtl/subtr_div_ctrl_if.sv
// Handshake and operand/result bundle for the restoring divider.
// The requester drives through master; the divider sits on slave.
interface subtr_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/subtr_div_ctrl.sv
// Unsigned restoring divider: one (WIDTH+1)-bit subtractor, one quotient bit per RUN cycle.
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | WIDTH shift/subtract iterations
// DONE  | one-cycle done pulse, then back to IDLE
module subtr_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    subtr_div_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // dvd shifts dividend bits out at the top while quotient bits shift in at the bottom
    always_comb begin
        partial  = {rem, dvd[WIDTH-1]};
        diff     = partial - {1'b0, dsr};
        borrow   = diff[WIDTH];
        rem_next = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next   = {dvd[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            dvd             <= '0;
            dsr             <= '0;
            rem             <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd             <= bus.dividend;
                        dsr             <= bus.divisor;
                        cnt             <= '0;
                        rem             <= '0;
                        bus.busy        <= 1'b1;
                        bus.div_by_zero <= 1'b0;
                        if (bus.divisor == '0) begin
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= q_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.quotient  <= q_next;
                        bus.remainder <= rem_next;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
